// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, NOP word, FSM states.
// Optional feature macro used by the top: CONTADOR_INSTR_EN.
package unidade_busca_pkg;

  localparam int LARG_END = 11;

  localparam logic [4:0] OPC_JUMP = 5'b10010;
  localparam logic [4:0] OPC_JN   = 5'b10100;
  localparam logic [4:0] OPC_JZ   = 5'b10110;
  localparam logic [4:0] OPC_IN   = 5'b11000;
  localparam logic [4:0] OPC_OUT  = 5'b11001;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HLT  = 5'b11011;

  localparam logic [31:0] PALAVRA_NOP_PADRAO = {OPC_NOP, 27'd0};

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_t;

endpackage

// File: rtl/unidade_busca_contador_pc.sv
// PC register (row, column) with increment and row wrap, plus branch-target load and range check.
// Latency: new PC visible one cycle after avanca/carrega.
// Backpressure: holds its value whenever neither avanca nor carrega is asserted.
module unidade_busca_contador_pc #(
  parameter int TAMANHO = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        avanca,
  input  logic        carrega,
  input  logic [10:0] alvo_linha,
  input  logic [10:0] alvo_coluna,
  output logic [10:0] linha,
  output logic [10:0] coluna,
  output logic        alvo_valido
);

  localparam logic [10:0] ULTIMO = 11'(TAMANHO - 1);

  assign alvo_valido = (alvo_linha <= ULTIMO) && (alvo_coluna <= ULTIMO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      linha  <= 11'd0;
      coluna <= 11'd0;
    end else if (carrega && alvo_valido) begin
      linha  <= alvo_linha;
      coluna <= alvo_coluna;
    end else if (avanca) begin
      if (coluna == ULTIMO) begin
        coluna <= 11'd0;
        linha  <= (linha == ULTIMO) ? 11'd0 : linha + 11'd1;
      end else begin
        coluna <= coluna + 11'd1;
      end
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: drives RAM address, captures the word into the IR, hands it off valid/ready.
// Latency: address to instr_valida is 1 cycle; 1 instruction/cycle while instr_pronta stays high.
// Backpressure: IR and PC hold while instr_valida && !instr_pronta. Optional counter: CONTADOR_INSTR_EN.
module unidade_busca #(
  parameter int          TAMANHO     = 40,
  parameter logic [4:0]  OP_HLT      = unidade_busca_pkg::OPC_HLT,
  parameter logic [31:0] PALAVRA_NOP = unidade_busca_pkg::PALAVRA_NOP_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrucao,
  output logic [10:0] end_linha,
  output logic [10:0] end_coluna,
  output logic [31:0] instr_out,
  output logic [10:0] instr_linha,
  output logic [10:0] instr_coluna,
  output logic        instr_valida,
  input  logic        instr_pronta,
  input  logic        desvio,
  input  logic [10:0] desvio_linha,
  input  logic [10:0] desvio_coluna,
  output logic        parado,
  output logic        erro_endereco
`ifdef CONTADOR_INSTR_EN
  ,
  output logic [31:0] total_instr
`endif
);

  import unidade_busca_pkg::*;

  estado_t estado, prox_estado;
  logic    captura, avanca, carrega, descarta, marca_erro, alvo_valido, entrega;

  assign entrega = instr_valida && instr_pronta;
  assign parado  = (estado == PARADO);

  unidade_busca_contador_pc #(
    .TAMANHO(TAMANHO)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .avanca     (avanca),
    .carrega    (carrega),
    .alvo_linha (desvio_linha),
    .alvo_coluna(desvio_coluna),
    .linha      (end_linha),
    .coluna     (end_coluna),
    .alvo_valido(alvo_valido)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIO;
    else        estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    captura     = 1'b0;
    avanca      = 1'b0;
    carrega     = 1'b0;
    descarta    = 1'b0;
    marca_erro  = 1'b0;
    case (estado)
      INICIO, BUSCA: begin
        if (estado == INICIO) prox_estado = BUSCA;
        // A branch wins over both capture and HLT detection in the same cycle.
        if (desvio) begin
          descarta = 1'b1;
          if (alvo_valido) begin
            carrega = 1'b1;
          end else begin
            marca_erro  = 1'b1;
            prox_estado = PARADO;
          end
        end else if (estado == BUSCA && (!instr_valida || instr_pronta)) begin
          captura = 1'b1;
          if (instrucao[31:27] == OP_HLT) prox_estado = PARADO;
          else                            avanca      = 1'b1;
        end
      end
      PARADO: prox_estado = PARADO;
      default: prox_estado = INICIO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_out     <= PALAVRA_NOP;
      instr_linha   <= 11'd0;
      instr_coluna  <= 11'd0;
      instr_valida  <= 1'b0;
      erro_endereco <= 1'b0;
    end else begin
      if (captura) begin
        instr_out    <= instrucao;
        instr_linha  <= end_linha;
        instr_coluna <= end_coluna;
      end
      if (descarta)     instr_valida <= 1'b0;
      else if (captura) instr_valida <= 1'b1;
      else if (entrega) instr_valida <= 1'b0;
      if (marca_erro) erro_endereco <= 1'b1;
    end
  end

`ifdef CONTADOR_INSTR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   total_instr <= 32'd0;
    else if (entrega && total_instr != 32'hFFFF_FFFF) total_instr <= total_instr + 32'd1;
  end
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: vector table, directed corner sequences, random vs. reference model.
module tb_unidade_busca;

  localparam int T = 40;
  localparam int N = T * T;
  localparam logic [31:0] W_NOP = 32'hD000_0000;
  localparam logic [31:0] W_HLT = 32'hD800_0000;
  localparam logic [31:0] W_IN  = 32'hC000_0000;
  localparam logic [31:0] W_OUT = 32'hC800_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_pronta = 1'b0;
  logic        desvio = 1'b0;
  logic [10:0] desvio_linha = 11'd0;
  logic [10:0] desvio_coluna = 11'd0;
  logic [31:0] instrucao;
  logic [10:0] end_linha, end_coluna, instr_linha, instr_coluna;
  logic [31:0] instr_out;
  logic        instr_valida, parado, erro_endereco;
`ifdef CONTADOR_INSTR_EN
  logic [31:0] total_instr;
`endif

  unidade_busca dut (
    .clock        (clock),
    .reset        (reset),
    .instrucao    (instrucao),
    .end_linha    (end_linha),
    .end_coluna   (end_coluna),
    .instr_out    (instr_out),
    .instr_linha  (instr_linha),
    .instr_coluna (instr_coluna),
    .instr_valida (instr_valida),
    .instr_pronta (instr_pronta),
    .desvio       (desvio),
    .desvio_linha (desvio_linha),
    .desvio_coluna(desvio_coluna),
    .parado       (parado),
    .erro_endereco(erro_endereco)
`ifdef CONTADOR_INSTR_EN
    ,
    .total_instr  (total_instr)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural instruction RAM with combinational read.
  logic [31:0] mem [0:N-1];
  always_comb begin
    instrucao = 32'h0;
    if (end_linha < 11'd40 && end_coluna < 11'd40)
      instrucao = mem[int'(end_linha) * T + int'(end_coluna)];
  end

  int checks = 0;
  int failures = 0;
  int watch = -1;
  int n_watch = 0;

  // Reference model: PC as a linear index over the T*T matrix.
  int          m_pc, m_irpc;
  bit          m_inicio, m_parado, m_err, m_val;
  logic [31:0] m_ir, m_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 0; m_irpc = 0; m_inicio = 1; m_parado = 0; m_err = 0; m_val = 0;
    m_ir = W_NOP; m_total = 0;
  endtask

  task automatic m_step(input logic p, input logic d, input int dl, input int dc);
    bit          hand;
    logic [31:0] w;
    hand = m_val && p;
    if (hand && m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
    if (m_parado) begin
      if (hand) m_val = 0;
    end else if (d) begin
      m_val = 0;
      m_inicio = 0;
      if (dl < T && dc < T) m_pc = dl * T + dc;
      else begin m_err = 1; m_parado = 1; end
    end else if (m_inicio) begin
      m_inicio = 0;
    end else if (!m_val || p) begin
      w = mem[m_pc];
      m_ir = w; m_irpc = m_pc; m_val = 1;
      if (w[31:27] == 5'b11011) m_parado = 1;
      else m_pc = (m_pc + 1) % N;
    end
  endtask

  task automatic cmp_model();
    chk("end_linha", 32'(end_linha), 32'(m_pc / T));
    chk("end_coluna", 32'(end_coluna), 32'(m_pc % T));
    chk("instr_valida", 32'(instr_valida), 32'(m_val));
    chk("instr_out", instr_out, m_ir);
    chk("instr_linha", 32'(instr_linha), 32'(m_irpc / T));
    chk("instr_coluna", 32'(instr_coluna), 32'(m_irpc % T));
    chk("parado", 32'(parado), 32'(m_parado));
    chk("erro_endereco", 32'(erro_endereco), 32'(m_err));
`ifdef CONTADOR_INSTR_EN
    chk("total_instr", total_instr, m_total);
`endif
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic p, input logic d, input logic [10:0] dl, input logic [10:0] dc);
    instr_pronta = p; desvio = d; desvio_linha = dl; desvio_coluna = dc;
    #1;
    if (instr_valida && p && instr_linha == 11'd0 && int'(instr_coluna) == watch) n_watch++;
    m_step(p, d, int'(dl), int'(dc));
    @(posedge clock); #1;
    cmp_model();
    @(negedge clock);
    desvio = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; instr_pronta = 1'b0; desvio = 1'b0;
    m_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < N; i++) mem[i] = W_NOP | 32'(i);
    mem[0] = W_NOP; mem[1] = W_NOP; mem[2] = W_IN; mem[3] = W_OUT;
    mem[23] = W_HLT;
  endtask

  typedef struct {
    logic        pronta;
    logic        val;
    logic [10:0] col;
    logic [10:0] pc_col;
    logic [31:0] word;
  } vec_t;

  vec_t vt [11];

  initial begin
    fill_mem();
    vt[0]  = '{1'b1, 1'b0, 11'd0, 11'd0, W_NOP};
    vt[1]  = '{1'b1, 1'b1, 11'd0, 11'd1, W_NOP};
    vt[2]  = '{1'b1, 1'b1, 11'd1, 11'd2, W_NOP};
    vt[3]  = '{1'b1, 1'b1, 11'd2, 11'd3, W_IN};
    vt[4]  = '{1'b1, 1'b1, 11'd3, 11'd4, W_OUT};
    vt[5]  = '{1'b1, 1'b1, 11'd4, 11'd5, 32'hD000_0004};
    vt[6]  = '{1'b0, 1'b1, 11'd4, 11'd5, 32'hD000_0004};
    vt[7]  = '{1'b0, 1'b1, 11'd4, 11'd5, 32'hD000_0004};
    vt[8]  = '{1'b0, 1'b1, 11'd4, 11'd5, 32'hD000_0004};
    vt[9]  = '{1'b1, 1'b1, 11'd5, 11'd6, 32'hD000_0005};
    vt[10] = '{1'b1, 1'b1, 11'd6, 11'd7, 32'hD000_0006};

    // Reset state while reset is held low.
    #12;
    chk("rst_instr_out", instr_out, W_NOP);
    chk("rst_valida", 32'(instr_valida), 32'd0);
    chk("rst_parado", 32'(parado), 32'd0);
    chk("rst_erro", 32'(erro_endereco), 32'd0);
    chk("rst_end", {10'd0, end_linha, end_coluna}, 32'd0);
    chk("rst_instr_addr", {10'd0, instr_linha, instr_coluna}, 32'd0);

    // Straight line and backpressure.
    do_reset();
    watch = 4; n_watch = 0;
    for (int i = 0; i < 11; i++) begin
      step(vt[i].pronta, 1'b0, 11'd0, 11'd0);
      chk($sformatf("tab%0d_valida", i), 32'(instr_valida), 32'(vt[i].val));
      chk($sformatf("tab%0d_col", i), 32'(instr_coluna), 32'(vt[i].col));
      chk($sformatf("tab%0d_pc", i), 32'(end_coluna), 32'(vt[i].pc_col));
      chk($sformatf("tab%0d_word", i), instr_out, vt[i].word);
    end
    chk("bp_delivered_once", 32'(n_watch), 32'd1);

    // Row wrap and full wrap.
    do_reset();
    step(1'b1, 1'b0, 11'd0, 11'd0);
    step(1'b1, 1'b1, 11'd0, 11'd39);
    step(1'b1, 1'b0, 11'd0, 11'd0);
    chk("wrap_row", {10'd0, end_linha, end_coluna}, {10'd0, 11'd1, 11'd0});
    step(1'b1, 1'b1, 11'd39, 11'd39);
    step(1'b1, 1'b0, 11'd0, 11'd0);
    chk("wrap_all", {10'd0, end_linha, end_coluna}, 32'd0);
    chk("wrap_ir", {10'd0, instr_linha, instr_coluna}, {10'd0, 11'd39, 11'd39});

    // Branch flush while IR holds (0,18).
    do_reset();
    for (int i = 0; i < 40 && !(instr_valida && instr_coluna == 11'd18); i++)
      step(1'b1, 1'b0, 11'd0, 11'd0);
    chk("br_reach18", 32'(instr_coluna), 32'd18);
    step(1'b1, 1'b1, 11'd0, 11'd9);
    chk("br_flush", 32'(instr_valida), 32'd0);
    step(1'b1, 1'b0, 11'd0, 11'd0);
    chk("br_target_col", 32'(instr_coluna), 32'd9);
    chk("br_target_word", instr_out, 32'hD000_0009);

    // HLT at (0,23).
    do_reset();
    watch = 23; n_watch = 0;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 11'd0, 11'd0);
    step(1'b1, 1'b1, 11'd0, 11'd5);
    step(1'b1, 1'b0, 11'd0, 11'd0);
    chk("hlt_once", 32'(n_watch), 32'd1);
    chk("hlt_parado", 32'(parado), 32'd1);
    chk("hlt_pc", {10'd0, end_linha, end_coluna}, {10'd0, 11'd0, 11'd23});
`ifdef CONTADOR_INSTR_EN
    chk("hlt_total", total_instr, 32'd24);
`endif

    // Out-of-range branch target.
    do_reset();
    step(1'b1, 1'b0, 11'd0, 11'd0);
    step(1'b1, 1'b0, 11'd0, 11'd0);
    step(1'b1, 1'b1, 11'd0, 11'd40);
    chk("bad_erro", 32'(erro_endereco), 32'd1);
    chk("bad_parado", 32'(parado), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 11'd0, 11'd0);
    chk("bad_sticky", 32'(erro_endereco), 32'd1);
    do_reset();
    chk("bad_rst_erro", 32'(erro_endereco), 32'd0);
    chk("bad_rst_parado", 32'(parado), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < N; i++) begin
      mem[i] = $urandom;
      if (mem[i][31:27] == 5'b11011 && $urandom_range(0, 15) != 0) mem[i][31:27] = 5'b11010;
    end
    begin
      int stuck;
      logic [10:0] dl, dc;
      stuck = 0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        dl = ($urandom_range(0, 11) == 0) ? 11'($urandom_range(40, 2047)) : 11'($urandom_range(0, 39));
        dc = ($urandom_range(0, 11) == 0) ? 11'($urandom_range(40, 2047)) : 11'($urandom_range(0, 39));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, dl, dc);
        stuck = m_parado ? stuck + 1 : 0;
        if (stuck > 8) begin
          do_reset();
          stuck = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
